// File: rtl/usb_txn_engine.sv
// Host-side USB transaction engine: runs OUT/IN transactions with per-endpoint
// DATA0/DATA1 toggle tracking, whole-transaction retry and a wait-state timeout.
module usb_txn_engine #(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned MAX_RETRY   = 8,
    parameter int unsigned TIMEOUT_LEN = 255,
    parameter int unsigned TO_W        = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_b,
    input  logic                                 txn_start,
    input  logic                                 txn_dir,
    input  logic [6:0]                           txn_addr,
    input  logic [3:0]                           txn_endp,
    input  logic [DATA_W-1:0]                    txn_wdata,
    input  logic                                 clear_toggles,
    output logic                                 txn_busy,
    output logic                                 txn_done,
    output logic                                 txn_ok,
    output logic [DATA_W-1:0]                    txn_rdata,
    output logic [$clog2(MAX_RETRY+1)-1:0]       txn_retries,
    output logic                                 tx_valid,
    output logic [7:0]                           tx_pid,
    output logic [6:0]                           tx_addr,
    output logic [3:0]                           tx_endp,
    output logic [DATA_W-1:0]                    tx_payload,
    input  logic                                 tx_ready,
    input  logic                                 rx_valid,
    input  logic [7:0]                           rx_pid,
    input  logic [DATA_W-1:0]                    rx_payload,
    input  logic                                 rx_corrupt
);

    localparam int unsigned RET_W = $clog2(MAX_RETRY + 1);

    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_ACK   = 8'hD2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TOKEN,
        S_OUT_DATA,
        S_WAIT_HS,
        S_WAIT_DATA,
        S_SEND_ACK,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic                dir_q, dir_d;
    logic [6:0]          addr_q, addr_d;
    logic [3:0]          endp_q, endp_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                tog_q, tog_d;
    logic                dup_q, dup_d;
    logic [15:0]         toggles_q, toggles_d;
    logic [RET_W-1:0]    retries_q, retries_d;
    logic [TO_W-1:0]     timer_q, timer_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ok_q, ok_d;
    logic                tx_valid_q, tx_valid_d;
    logic [7:0]          tx_pid_q, tx_pid_d;
    logic [6:0]          tx_addr_q, tx_addr_d;
    logic [3:0]          tx_endp_q, tx_endp_d;
    logic [DATA_W-1:0]   tx_payload_q, tx_payload_d;

    logic                timeout_c;
    logic                rx_clean_c;
    logic                rx_is_data_c;

    assign timeout_c    = (timer_q == TO_W'(TIMEOUT_LEN));
    assign rx_clean_c   = rx_valid && !rx_corrupt;
    assign rx_is_data_c = (rx_pid == PID_DATA0) || (rx_pid == PID_DATA1);

    // Next-state, toggle bookkeeping and registered-output decode
    always_comb begin
        logic fail;
        logic flip;

        state_d   = state_q;
        dir_d     = dir_q;
        addr_d    = addr_q;
        endp_d    = endp_q;
        wdata_d   = wdata_q;
        tog_d     = tog_q;
        dup_d     = dup_q;
        retries_d = retries_q;
        timer_d   = timer_q;
        rdata_d   = rdata_q;
        ok_d      = 1'b0;
        fail      = 1'b0;
        flip      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (txn_start) begin
                    dir_d     = txn_dir;
                    addr_d    = txn_addr;
                    endp_d    = txn_endp;
                    wdata_d   = txn_wdata;
                    tog_d     = toggles_q[txn_endp];
                    dup_d     = 1'b0;
                    retries_d = '0;
                    state_d   = S_TOKEN;
                end
            end
            S_TOKEN: begin
                if (tx_ready) begin
                    timer_d = '0;
                    state_d = dir_q ? S_WAIT_DATA : S_OUT_DATA;
                end
            end
            S_OUT_DATA: begin
                if (tx_ready) begin
                    timer_d = '0;
                    state_d = S_WAIT_HS;
                end
            end
            S_WAIT_HS: begin
                timer_d = timer_q + TO_W'(1);
                if (rx_valid) begin
                    if (rx_clean_c && (rx_pid == PID_ACK)) begin
                        flip    = 1'b1;
                        ok_d    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (timeout_c) begin
                    fail = 1'b1;
                end
            end
            S_WAIT_DATA: begin
                timer_d = timer_q + TO_W'(1);
                if (rx_valid) begin
                    if (rx_clean_c && rx_is_data_c) begin
                        // Matching toggle is new data; mismatch is a resent duplicate
                        if ((rx_pid == PID_DATA1) == tog_q) begin
                            rdata_d = rx_payload;
                            flip    = 1'b1;
                            dup_d   = 1'b0;
                        end else begin
                            dup_d   = 1'b1;
                        end
                        state_d = S_SEND_ACK;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (timeout_c) begin
                    fail = 1'b1;
                end
            end
            S_SEND_ACK: begin
                if (tx_ready) begin
                    if (dup_q) begin
                        fail = 1'b1;
                    end else begin
                        ok_d    = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Failed attempt: resend the whole transaction or give up
        if (fail) begin
            dup_d = 1'b0;
            if (retries_q < RET_W'(MAX_RETRY)) begin
                retries_d = retries_q + RET_W'(1);
                state_d   = S_TOKEN;
            end else begin
                ok_d    = 1'b0;
                state_d = S_DONE;
            end
        end

        toggles_d = toggles_q;
        if (flip) begin
            toggles_d[endp_q] = ~toggles_q[endp_q];
        end
        if (clear_toggles) begin
            toggles_d = '0;
        end

        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
        tx_valid_d   = (state_d == S_TOKEN) || (state_d == S_OUT_DATA) ||
                       (state_d == S_SEND_ACK);
        tx_pid_d     = 8'h00;
        tx_addr_d    = 7'd0;
        tx_endp_d    = 4'd0;
        tx_payload_d = '0;
        unique case (state_d)
            S_TOKEN: begin
                tx_pid_d  = dir_d ? PID_IN : PID_OUT;
                tx_addr_d = addr_d;
                tx_endp_d = endp_d;
            end
            S_OUT_DATA: begin
                tx_pid_d     = tog_d ? PID_DATA1 : PID_DATA0;
                tx_payload_d = wdata_d;
            end
            S_SEND_ACK: begin
                tx_pid_d = PID_ACK;
            end
            default: begin
                tx_pid_d = 8'h00;
            end
        endcase
    end

    // State, transaction context and output registers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= S_IDLE;
            dir_q        <= 1'b0;
            addr_q       <= 7'd0;
            endp_q       <= 4'd0;
            wdata_q      <= '0;
            tog_q        <= 1'b0;
            dup_q        <= 1'b0;
            toggles_q    <= '0;
            retries_q    <= '0;
            timer_q      <= '0;
            rdata_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ok_q         <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_pid_q     <= 8'h00;
            tx_addr_q    <= 7'd0;
            tx_endp_q    <= 4'd0;
            tx_payload_q <= '0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            addr_q       <= addr_d;
            endp_q       <= endp_d;
            wdata_q      <= wdata_d;
            tog_q        <= tog_d;
            dup_q        <= dup_d;
            toggles_q    <= toggles_d;
            retries_q    <= retries_d;
            timer_q      <= timer_d;
            rdata_q      <= rdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ok_q         <= ok_d;
            tx_valid_q   <= tx_valid_d;
            tx_pid_q     <= tx_pid_d;
            tx_addr_q    <= tx_addr_d;
            tx_endp_q    <= tx_endp_d;
            tx_payload_q <= tx_payload_d;
        end
    end

    assign txn_busy    = busy_q;
    assign txn_done    = done_q;
    assign txn_ok      = ok_q;
    assign txn_rdata   = rdata_q;
    assign txn_retries = retries_q;
    assign tx_valid    = tx_valid_q;
    assign tx_pid      = tx_pid_q;
    assign tx_addr     = tx_addr_q;
    assign tx_endp     = tx_endp_q;
    assign tx_payload  = tx_payload_q;

endmodule

// File: tb/tb_usb_txn_engine.sv
// Directed self-checking bench for usb_txn_engine (encoder always ready).
module tb_usb_txn_engine;

    localparam int unsigned DATA_W = 64;

    logic              clk;
    logic              rst_b;
    logic              txn_start;
    logic              txn_dir;
    logic [6:0]        txn_addr;
    logic [3:0]        txn_endp;
    logic [DATA_W-1:0] txn_wdata;
    logic              clear_toggles;
    logic              txn_busy;
    logic              txn_done;
    logic              txn_ok;
    logic [DATA_W-1:0] txn_rdata;
    logic [3:0]        txn_retries;
    logic              tx_valid;
    logic [7:0]        tx_pid;
    logic [6:0]        tx_addr;
    logic [3:0]        tx_endp;
    logic [DATA_W-1:0] tx_payload;
    logic              tx_ready;
    logic              rx_valid;
    logic [7:0]        rx_pid;
    logic [DATA_W-1:0] rx_payload;
    logic              rx_corrupt;

    int n_cmp = 0;
    int n_err = 0;

    usb_txn_engine dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .txn_start     (txn_start),
        .txn_dir       (txn_dir),
        .txn_addr      (txn_addr),
        .txn_endp      (txn_endp),
        .txn_wdata     (txn_wdata),
        .clear_toggles (clear_toggles),
        .txn_busy      (txn_busy),
        .txn_done      (txn_done),
        .txn_ok        (txn_ok),
        .txn_rdata     (txn_rdata),
        .txn_retries   (txn_retries),
        .tx_valid      (tx_valid),
        .tx_pid        (tx_pid),
        .tx_addr       (tx_addr),
        .tx_endp       (tx_endp),
        .tx_payload    (tx_payload),
        .tx_ready      (tx_ready),
        .rx_valid      (rx_valid),
        .rx_pid        (rx_pid),
        .rx_payload    (rx_payload),
        .rx_corrupt    (rx_corrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_txn(input logic dir, input logic [6:0] addr, input logic [3:0] endp,
                             input logic [63:0] wdata);
        txn_dir   = dir;
        txn_addr  = addr;
        txn_endp  = endp;
        txn_wdata = wdata;
        txn_start = 1'b1;
        tick();
        txn_start = 1'b0;
    endtask

    // Wait for an offered packet, check its PID, let the encoder take it
    task automatic next_pkt(input string tag, input logic [7:0] exp_pid, output int waited);
        waited = 0;
        while (!tx_valid && waited < 400) begin
            tick();
            waited++;
        end
        check_val(tag, 64'({tx_valid, tx_pid}), 64'({1'b1, exp_pid}));
        tick();
    endtask

    task automatic rx_pulse(input logic [7:0] pid, input logic [63:0] payload, input logic corrupt);
        rx_valid   = 1'b1;
        rx_pid     = pid;
        rx_payload = payload;
        rx_corrupt = corrupt;
        tick();
        rx_valid   = 1'b0;
        rx_corrupt = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic exp_ok, input logic [3:0] exp_ret,
                             output int waited);
        waited = 0;
        while (!txn_done && waited < 400) begin
            tick();
            waited++;
        end
        check_val({tag, "_done"}, 64'(txn_done), 64'd1);
        check_val({tag, "_ok"}, 64'(txn_ok), 64'(exp_ok));
        check_val({tag, "_retries"}, 64'(txn_retries), 64'(exp_ret));
        tick();
    endtask

    initial begin
        int w;
        bit saw_done;

        rst_b = 1'b0; txn_start = 1'b0; txn_dir = 1'b0; txn_addr = '0; txn_endp = '0;
        txn_wdata = '0; clear_toggles = 1'b0; tx_ready = 1'b1; rx_valid = 1'b0;
        rx_pid = '0; rx_payload = '0; rx_corrupt = 1'b0;
        repeat (3) tick();
        check_val("rst_busy", 64'(txn_busy), 64'd0);
        check_val("rst_txvalid", 64'(tx_valid), 64'd0);
        check_val("rst_pid", 64'(tx_pid), 64'd0);
        check_val("rst_rdata", txn_rdata, 64'd0);
        rst_b = 1'b1;
        tick();

        // OUT endp 3, immediate ACK: best-case latency 4 cycles
        start_txn(1'b0, 7'h15, 4'd3, 64'hA5A5_0000_1111_2222);
        check_val("t1_addr", 64'({tx_valid, tx_addr, tx_endp}), 64'({1'b1, 7'h15, 4'd3}));
        next_pkt("t1_tok", 8'hE1, w);
        check_val("t1_payload", tx_payload, 64'hA5A5_0000_1111_2222);
        next_pkt("t1_data", 8'hC3, w);
        check_val("t1_wait_idle", 64'(tx_valid), 64'd0);
        rx_pulse(8'hD2, 64'd0, 1'b0);
        check_val("t1_latency", 64'(txn_done), 64'd1);
        wait_done("t1", 1'b1, 4'd0, w);
        check_val("t1_idle_busy", 64'(txn_busy), 64'd0);

        // Second OUT to endp 3 uses DATA1
        start_txn(1'b0, 7'h15, 4'd3, 64'h0);
        next_pkt("t1b_tok", 8'hE1, w);
        next_pkt("t1b_data", 8'h4B, w);
        rx_pulse(8'hD2, 64'd0, 1'b0);
        wait_done("t1b", 1'b1, 4'd0, w);

        // OUT endp 1: NAK, NAK, ACK
        start_txn(1'b0, 7'h02, 4'd1, 64'h1234);
        for (int i = 0; i < 3; i++) begin
            next_pkt("t2_tok", 8'hE1, w);
            next_pkt("t2_data", 8'hC3, w);
            rx_pulse((i < 2) ? 8'h5A : 8'hD2, 64'd0, 1'b0);
        end
        wait_done("t2", 1'b1, 4'd2, w);

        // IN endp 2, decoder silent: 9 tokens, each followed by a full timeout
        start_txn(1'b1, 7'h03, 4'd2, 64'h0);
        for (int i = 0; i < 9; i++) begin
            next_pkt("t3_tok", 8'h69, w);
            if (i > 0) check_val("t3_gap", 64'(w), 64'd256);
        end
        wait_done("t3", 1'b0, 4'd8, w);
        check_val("t3_last_gap", 64'(w), 64'd256);

        // IN endp 4: duplicate DATA1 is ACKed and retried, then DATA0 accepted
        start_txn(1'b1, 7'h04, 4'd4, 64'h0);
        next_pkt("t4_tok1", 8'h69, w);
        rx_pulse(8'h4B, 64'hBAD0_BAD0_BAD0_BAD0, 1'b0);
        next_pkt("t4_dup_ack", 8'hD2, w);
        check_val("t4_rdata_kept", txn_rdata, 64'd0);
        check_val("t4_ret_mid", 64'(txn_retries), 64'd1);
        next_pkt("t4_tok2", 8'h69, w);
        rx_pulse(8'hC3, 64'hDEADBEEF_01234567, 1'b0);
        next_pkt("t4_ack", 8'hD2, w);
        wait_done("t4", 1'b1, 4'd1, w);
        check_val("t4_rdata", txn_rdata, 64'hDEADBEEF_01234567);

        // IN endp 4 (toggle now 1): corrupt -> no ACK; then packet at timeout wins
        start_txn(1'b1, 7'h04, 4'd4, 64'h0);
        next_pkt("t5_tok1", 8'h69, w);
        rx_pulse(8'h4B, 64'h1, 1'b1);
        next_pkt("t5_no_ack", 8'h69, w);
        repeat (255) tick();
        rx_pulse(8'h4B, 64'hCAFE_F00D_0000_0005, 1'b0);
        next_pkt("t5_ack", 8'hD2, w);
        wait_done("t5", 1'b1, 4'd1, w);
        check_val("t5_rdata", txn_rdata, 64'hCAFE_F00D_0000_0005);

        // clear_toggles coinciding with ACK-induced flip on endp 5
        start_txn(1'b0, 7'h05, 4'd5, 64'h55);
        next_pkt("t6_tok", 8'hE1, w);
        next_pkt("t6_data", 8'hC3, w);
        clear_toggles = 1'b1;
        rx_pulse(8'hD2, 64'd0, 1'b0);
        clear_toggles = 1'b0;
        wait_done("t6", 1'b1, 4'd0, w);
        start_txn(1'b0, 7'h05, 4'd5, 64'h56);
        next_pkt("t6b_tok", 8'hE1, w);
        next_pkt("t6b_data", 8'hC3, w);
        rx_pulse(8'hD2, 64'd0, 1'b0);
        wait_done("t6b", 1'b1, 4'd0, w);

        // Reset while in WAIT_HS: aborts silently
        start_txn(1'b0, 7'h06, 4'd6, 64'h66);
        next_pkt("t7_tok", 8'hE1, w);
        next_pkt("t7_data", 8'hC3, w);
        rst_b = 1'b0;
        #2;
        check_val("t7_rst_outs", 64'({txn_busy, txn_done, txn_ok, tx_valid, tx_pid, txn_retries}), 64'd0);
        check_val("t7_rst_rdata", txn_rdata, 64'd0);
        tick();
        rst_b = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (txn_done || txn_busy) saw_done = 1'b1;
            tick();
        end
        check_val("t7_no_done", 64'(saw_done), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/usb_txn_engine.md
# usb_txn_engine

Parametrised host-side USB transaction engine that runs complete OUT and IN transactions between the read/write layer and the packet encoder/decoder. It adds per-endpoint DATA0/DATA1 toggle tracking, full token-plus-data retransmission on NAK/corrupt/timeout, and configurable payload width, retry limit and timeout. It sits between the read/write FSM (upstream) and the bit-level encoder/decoder (downstream).

## Interface

- DATA_W, 64: payload bits per data packet (CRC is added and checked by encoder/decoder).
- MAX_RETRY, 8: retries after the first attempt; up to MAX_RETRY+1 attempts in total.
- TIMEOUT_LEN, 255: cycles in a wait state before a timeout.
- TO_W, 8: timer width; must satisfy 2^TO_W > TIMEOUT_LEN.

- clk  in  1  clock; all state updates on posedge.
- rst_b  in  1  reset, asynchronous, active-low.
- txn_start  in  1  pulse that starts a transaction; sampled only in IDLE.
- txn_dir  in  1  0 = OUT, 1 = IN; sampled with txn_start.
- txn_addr  in  7  device address; sampled with txn_start.
- txn_endp  in  4  endpoint; sampled with txn_start.
- txn_wdata  in  DATA_W  OUT payload; sampled with txn_start.
- clear_toggles  in  1  clears all 16 toggle bits to DATA0.
- txn_busy  out  1  high whenever the state is not IDLE.
- txn_done  out  1  one-cycle pulse when a transaction ends.
- txn_ok  out  1  success flag; valid only with txn_done, 0 otherwise.
- txn_rdata  out  DATA_W  IN payload; holds its value until the next accepted IN packet.
- txn_retries  out  $clog2(MAX_RETRY+1)  retries used by the current or last transaction.
- tx_valid  out  1  packet offered to the encoder.
- tx_pid  out  8  OUT = E1, IN = 69, DATA0 = C3, DATA1 = 4B, ACK = D2.
- tx_addr  out  7, tx_endp  out  4  token fields.
- tx_payload  out  DATA_W  data packet payload.
- tx_ready  in  1  encoder has sent the offered packet; takes effect only while tx_valid is high.
- rx_valid  in  1  one-cycle pulse: the decoder has a packet.
- rx_pid  in  8, rx_payload  in  DATA_W, rx_corrupt  in  1  packet contents, valid with rx_valid.

## Operation

- States: IDLE, TOKEN, OUT_DATA, WAIT_HS, WAIT_DATA, SEND_ACK, DONE.
- IDLE: txn_start latches the direction, address, endpoint, payload and the endpoint's toggle, clears the retry count, and moves to TOKEN.
- TOKEN: tx_valid is high and tx_pid is OUT or IN. On tx_ready, move to OUT_DATA (OUT) or WAIT_DATA (IN).
- OUT_DATA: tx_valid is high, tx_pid is DATA0/DATA1 from the endpoint toggle, and tx_payload is the latched txn_wdata. On tx_ready, move to WAIT_HS.
- WAIT_HS on a clean ACK: flip the endpoint toggle and move to DONE with ok.
- WAIT_HS on NAK, any other PID, a corrupt packet or timeout: this is a failed attempt.
- WAIT_DATA on a clean DATA PID that matches the toggle: latch rx_payload into txn_rdata, flip the toggle, and move to SEND_ACK.
- WAIT_DATA on a clean DATA PID with the wrong toggle (duplicate): discard the payload, send ACK, and mark the attempt failed after the ACK is sent.
- WAIT_DATA on NAK, a corrupt packet, any other PID or timeout: this is a failed attempt.
- SEND_ACK: tx_valid is high with tx_pid D2. On tx_ready, move to DONE with ok, or treat the attempt as failed if it was a duplicate.
- Failed attempt: if txn_retries < MAX_RETRY, increment txn_retries and return to TOKEN (the whole transaction is resent). Otherwise move to DONE with ok = 0.
- DONE: txn_done = 1 for one cycle, then IDLE.
- Toggle register: 16 bits, one per endpoint. clear_toggles has priority over a flip in the same cycle.
- tx_* fields stay stable while tx_valid is high. tx_valid is 0 in the IDLE, WAIT, and DONE states.
- Reset values: state IDLE, toggles 0, every output 0, txn_rdata 0.
- Reset asserted mid-transaction aborts with no txn_done.

## Timing

- txn_start in cycle N puts tx_valid high in cycle N+1.
- tx_ready in cycle M changes the state at the edge ending M. The next packet's tx_valid appears in M+1.
- Wait timer: 0 on entry to WAIT_HS or WAIT_DATA, incremented each cycle in the state. Timeout fires when the timer equals TIMEOUT_LEN.
- rx_valid in the same cycle as timeout: the packet wins.
- rx_valid outside the WAIT states is ignored.
- txn_start while busy is ignored.
- Best-case OUT with zero-latency tx_ready: token, data, ACK one cycle after data, done. txn_done comes 4 cycles after txn_start.

## Test plan

- OUT to endp 3, ACK on the first attempt: tx_pid E1 then C3. txn_done with ok = 1 and txn_retries = 0. Toggle[3] becomes 1, and the next OUT to endp 3 uses 4B.
- OUT with 2 NAKs then ACK: the token and data pair is sent 3 times. Result ok = 1, txn_retries = 2.
- IN with the decoder silent and MAX_RETRY = 8: 9 tokens are sent, each followed by a TIMEOUT_LEN wait. Result ok = 0, txn_retries = 8.
- IN with toggle 0: DATA1 (duplicate) gets an ACK and a retry. DATA0 with payload 64'hDEADBEEF_01234567 gets an ACK, txn_rdata equals that payload, ok = 1, txn_retries = 1.
- IN with a corrupt packet, then rx_valid in the same cycle as timeout: no ACK for the corrupt packet, the packet wins over timeout, and it is processed normally.
- clear_toggles in the same cycle as an ACK-induced flip leaves the toggle at 0. rst_b pulsed while in WAIT_HS gives IDLE with all outputs 0 and no txn_done.
